lane_engine: RTL and testbench

Parametrised multi-lane obstacle and game-state engine for the VGA crossy-road game. It replaces the fixed two-obstacle logic with:
- NUM_LANES independently moving obstacles with per-lane speed and direction.
- Frame-latched collision detection, a lives counter and a PLAY/FLASH/OVER state machine.
- A registered pixel colour output.

It sits between the VGA timing generator and the score overlay mux. Collisions no longer reset the whole design.

---
 rtl/crossy_pkg.sv | 17 +
 rtl/lane_obstacle.sv | 84 ++++++++
 rtl/lane_engine.sv | 175 +++++++++++++++++
 tb/tb_lane_engine.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crossy_pkg.sv
// crossy_pkg: shared state encoding and pixel colours
// for the crossy-road lane engine.
package crossy_pkg;

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    FLASH = 2'd1,
    OVER  = 2'd2
  } state_t;

  localparam logic [2:0] C_BLACK = 3'b000;
  localparam logic [2:0] C_BG    = 3'b001;
  localparam logic [2:0] C_CHICK = 3'b010;
  localparam logic [2:0] C_HIT   = 3'b011;
  localparam logic [2:0] C_OBST  = 3'b100;

endpackage

// File: rtl/lane_obstacle.sv
// lane_obstacle: one moving obstacle lane with wrap
// arithmetic and a per-pixel coverage flag.
module lane_obstacle
  import crossy_pkg::*;
#(
  parameter int LANE        = 0,
  parameter int NUM_LANES   = 4,
  parameter int SPEED_W     = 3,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int TOP_Y       = 32,
  parameter int LANE_PITCH  = 96,
  parameter int SCROLL_STEP = 16,
  parameter int OB_W        = 50,
  parameter int OB_H        = 30
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               restart,
  input  logic               frame_tick,
  input  logic               scroll,
  input  logic [SPEED_W-1:0] spd,
  input  logic               dir,
  input  logic [9:0]         hpos,
  input  logic [9:0]         vpos,
  output logic               obst
);

  localparam logic [10:0] HA = 11'(H_ACTIVE);
  localparam logic [10:0] VA = 11'(V_ACTIVE);
  localparam logic [10:0] TY = 11'(TOP_Y);
  localparam logic [10:0] SS = 11'(SCROLL_STEP);
  localparam logic [10:0] OW = 11'(OB_W);
  localparam logic [10:0] OH = 11'(OB_H);
  localparam logic [9:0]  X0 =
    10'(LANE * (H_ACTIVE / NUM_LANES));
  localparam logic [9:0]  Y0 =
    10'(TOP_Y + LANE * LANE_PITCH);

  logic [9:0]  x, y;
  logic [9:0]  x_nx, y_nx;
  logic [10:0] xw, yw, hw, vw, sw;
  logic [10:0] xt, yt, dx;

  always_comb begin
    xw = {1'b0, x};
    yw = {1'b0, y};
    hw = {1'b0, hpos};
    vw = {1'b0, vpos};
    sw = 11'(spd);
    xt = xw;
    if (!dir) begin
      xt = xw + sw;
      if (xt >= HA) xt = xt - HA;
    end else if (xw < sw) begin
      xt = xw + HA - sw;
    end else begin
      xt = xw - sw;
    end
    yt = yw + SS;
    if (yt >= VA) yt = yt - VA + TY;
    // distance from the lane origin, modulo screen width
    dx = (hw >= xw) ? hw - xw : hw + HA - xw;
    x_nx = 10'(xt);
    y_nx = 10'(yt);
  end

  assign obst = (dx < OW) && (vw >= yw) &&
                (vw < yw + OH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x <= X0;
      y <= Y0;
    end else if (restart) begin
      x <= X0;
      y <= Y0;
    end else begin
      if (frame_tick) x <= x_nx;
      if (scroll)     y <= y_nx;
    end
  end

endmodule

// File: rtl/lane_engine.sv
// lane_engine: multi-lane obstacles, collision,
// lives/state FSM and registered pixel colour.
module lane_engine
  import crossy_pkg::*;
#(
  parameter int NUM_LANES    = 4,
  parameter int SPEED_W      = 3,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int TOP_Y        = 32,
  parameter int LANE_PITCH   = 96,
  parameter int SCROLL_STEP  = 16,
  parameter int OB_W         = 50,
  parameter int OB_H         = 30,
  parameter int CHICKEN_X    = 310,
  parameter int CHICKEN_Y    = 400,
  parameter int CHICKEN_W    = 30,
  parameter int CHICKEN_H    = 40,
  parameter int LIVES        = 3,
  parameter int FLASH_FRAMES = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         frame_tick,
  input  logic                         move_btn,
  input  logic [9:0]                   hpos,
  input  logic [9:0]                   vpos,
  input  logic                         display_on,
  input  logic [NUM_LANES*SPEED_W-1:0] lane_speed,
  input  logic [NUM_LANES-1:0]         lane_dir,
  output logic [2:0]                   rgb,
  output logic [7:0]                   score,
  output logic [1:0]                   lives,
  output logic                         game_over,
  output logic                         collision
);

  localparam int FC = $clog2(FLASH_FRAMES + 1);
  localparam int FW = (FC < 3) ? 3 : FC;
  localparam logic [9:0] CX0 = 10'(CHICKEN_X);
  localparam logic [9:0] CX1 =
    10'(CHICKEN_X + CHICKEN_W);
  localparam logic [9:0] CY0 = 10'(CHICKEN_Y);
  localparam logic [9:0] CY1 =
    10'(CHICKEN_Y + CHICKEN_H);

  state_t          state, state_nx;
  logic [FW-1:0]   cnt, cnt_nx;
  logic [7:0]      score_nx;
  logic [1:0]      lives_nx;
  logic            coll_nx;
  logic            btn_q, press;
  logic            scroll, restart;
  logic            hit_seen, hit_nx;
  logic            chick, show_chick, obst;
  logic [2:0]      pix;
  logic [NUM_LANES-1:0] lane_hit;

  assign press   = move_btn & ~btn_q;
  assign scroll  = press & (state == PLAY);
  assign restart = press & (state == OVER);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_obstacle #(
      .LANE        (i),
      .NUM_LANES   (NUM_LANES),
      .SPEED_W     (SPEED_W),
      .H_ACTIVE    (H_ACTIVE),
      .V_ACTIVE    (V_ACTIVE),
      .TOP_Y       (TOP_Y),
      .LANE_PITCH  (LANE_PITCH),
      .SCROLL_STEP (SCROLL_STEP),
      .OB_W        (OB_W),
      .OB_H        (OB_H)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .restart    (restart),
      .frame_tick (frame_tick),
      .scroll     (scroll),
      .spd        (lane_speed[i*SPEED_W +: SPEED_W]),
      .dir        (lane_dir[i]),
      .hpos       (hpos),
      .vpos       (vpos),
      .obst       (lane_hit[i])
    );
  end

  assign obst  = |lane_hit;
  assign chick = (hpos >= CX0) && (hpos < CX1) &&
                 (vpos >= CY0) && (vpos < CY1);
  // chicken blinks while invulnerable
  assign show_chick =
    chick && !((state == FLASH) && cnt[2]);
  assign game_over = (state == OVER);

  always_comb begin
    hit_nx = hit_seen;
    if (frame_tick || restart) hit_nx = 1'b0;
    else if (display_on && chick && obst)
      hit_nx = 1'b1;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    lives_nx = lives;
    score_nx = score;
    coll_nx  = 1'b0;
    unique case (state)
      PLAY: begin
        if (press && score != 8'hFF)
          score_nx = score + 8'd1;
        if (frame_tick && hit_seen) begin
          coll_nx  = 1'b1;
          lives_nx = lives - 2'd1;
          cnt_nx   = FW'(FLASH_FRAMES);
          state_nx = (lives == 2'd1) ? OVER : FLASH;
        end
      end
      FLASH: begin
        if (frame_tick) begin
          if (cnt == FW'(1)) begin
            state_nx = PLAY;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt - FW'(1);
          end
        end
      end
      OVER: begin
        if (press) begin
          state_nx = PLAY;
          score_nx = '0;
          lives_nx = 2'(LIVES);
          cnt_nx   = '0;
        end
      end
      default: state_nx = PLAY;
    endcase
  end

  always_comb begin
    pix = C_BLACK;
    if (display_on) begin
      if (show_chick && obst)  pix = C_HIT;
      else if (obst)           pix = C_OBST;
      else if (show_chick)     pix = C_CHICK;
      else if (state != OVER)  pix = C_BG;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= PLAY;
      cnt       <= '0;
      lives     <= 2'(LIVES);
      score     <= '0;
      collision <= 1'b0;
      btn_q     <= 1'b0;
      hit_seen  <= 1'b0;
      rgb       <= C_BLACK;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      lives     <= lives_nx;
      score     <= score_nx;
      collision <= coll_nx;
      btn_q     <= move_btn;
      hit_seen  <= hit_nx;
      rgb       <= pix;
    end
  end

endmodule

// File: tb/tb_lane_engine.sv
// tb_lane_engine: scoreboard bench for lane_engine
// with a small behavioural model of lanes and score.
module tb_lane_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick, move_btn, display_on;
  logic [9:0]  hpos, vpos;
  logic [11:0] lane_speed;
  logic [3:0]  lane_dir;
  logic [2:0]  rgb;
  logic [7:0]  score;
  logic [1:0]  lives;
  logic        game_over, collision;

  lane_engine dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .move_btn   (move_btn),
    .hpos       (hpos),
    .vpos       (vpos),
    .display_on (display_on),
    .lane_speed (lane_speed),
    .lane_dir   (lane_dir),
    .rgb        (rgb),
    .score      (score),
    .lives      (lives),
    .game_over  (game_over),
    .collision  (collision)
  );

  always #5 clk = ~clk;

  logic [9:0] dut_x [4];
  logic [9:0] dut_y [4];
  for (genvar g = 0; g < 4; g++) begin : g_tap
    assign dut_x[g] = dut.g_lane[g].u_lane.x;
    assign dut_y[g] = dut.g_lane[g].u_lane.y;
  end

  localparam int S_PLAY  = 0;
  localparam int S_FLASH = 1;
  localparam int S_OVER  = 2;

  int n_checks = 0;
  int n_errors = 0;
  int exp_q[$];
  int mx[4], my[4];
  int mscore, mst;
  int sp[4];
  bit dr[4];

  task automatic chk(input string tag,
                     input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      mx[i] = 160 * i;
      my[i] = 32 + 96 * i;
    end
    mscore = 0;
    mst = S_PLAY;
  endtask

  function automatic int nxx(int x, int s, bit d);
    int r;
    if (!d) begin
      r = x + s;
      if (r >= 640) r = r - 640;
    end else if (x < s) begin
      r = x + 640 - s;
    end else begin
      r = x - s;
    end
    return r;
  endfunction

  function automatic int exp_rgb(int h, int v,
      bit de, bit hide, bit over);
    bit ob = 1'b0;
    bit ch;
    for (int i = 0; i < 4; i++)
      if (((h - mx[i] + 640) % 640) < 50 &&
          v >= my[i] && v < my[i] + 30)
        ob = 1'b1;
    ch = !hide && h >= 310 && h < 340 &&
         v >= 400 && v < 440;
    if (!de) return 0;
    if (ch && ob) return 3;
    if (ob) return 4;
    if (ch) return 2;
    return over ? 0 : 1;
  endfunction

  task automatic model_press();
    if (mst == S_PLAY) begin
      for (int i = 0; i < 4; i++) begin
        my[i] = my[i] + 16;
        if (my[i] >= 480) my[i] = my[i] - 480 + 32;
      end
      if (mscore < 255) mscore++;
    end else if (mst == S_OVER) begin
      model_reset();
    end
    exp_q.push_back(mscore);
    for (int i = 0; i < 4; i++)
      exp_q.push_back(my[i]);
  endtask

  task automatic check_press();
    chk("score", int'(score), exp_q.pop_front());
    for (int i = 0; i < 4; i++)
      chk("lane_y", int'(dut_y[i]), exp_q.pop_front());
  endtask

  task automatic press();
    model_press();
    move_btn = 1'b1;
    step();
    move_btn = 1'b0;
    check_press();
    step();
  endtask

  task automatic tick(input bit pr, input int ec);
    for (int i = 0; i < 4; i++) begin
      lane_speed[i*3 +: 3] = 3'(sp[i]);
      lane_dir[i] = dr[i];
      mx[i] = nxx(mx[i], sp[i], dr[i]);
      exp_q.push_back(mx[i]);
    end
    if (pr) model_press();
    frame_tick = 1'b1;
    move_btn = pr;
    step();
    frame_tick = 1'b0;
    move_btn = 1'b0;
    for (int i = 0; i < 4; i++)
      chk("lane_x", int'(dut_x[i]), exp_q.pop_front());
    if (pr) check_press();
    chk("collision", int'(collision), ec);
    step();
    chk("coll_pulse", int'(collision), 0);
  endtask

  task automatic pix(input int h, input int v,
      input bit de, input bit hide, input bit over);
    int e;
    e = exp_rgb(h, v, de, hide, over);
    hpos = 10'(h);
    vpos = 10'(v);
    display_on = de;
    step();
    display_on = 1'b0;
    chk("rgb", int'(rgb), e);
  endtask

  task automatic do_hit(input int lv, input int st);
    pix(320, 400, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1);
    chk("lives", int'(lives), lv);
    chk("state", int'(dut.state), st);
    mst = st;
  endtask

  task automatic flash_run();
    for (int k = 1; k <= 32; k++) begin
      tick(1'b0, 0);
      chk("flash_st", int'(dut.state),
          (k < 32) ? S_FLASH : S_PLAY);
      if (k == 4) begin
        pix(310, 420, 1'b1, 1'b1, 1'b0);
        pix(320, 400, 1'b1, 1'b1, 1'b0);
        press();
      end
    end
    mst = S_PLAY;
  endtask

  initial begin
    reset = 1'b1;
    frame_tick = 1'b0;
    move_btn = 1'b0;
    display_on = 1'b0;
    hpos = '0;
    vpos = '0;
    lane_speed = '0;
    lane_dir = '0;
    for (int i = 0; i < 4; i++) begin
      sp[i] = 0;
      dr[i] = 1'b0;
    end
    model_reset();
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      chk("rst_x", int'(dut_x[i]), 160 * i);
      chk("rst_y", int'(dut_y[i]), 32 + 96 * i);
    end
    chk("rst_lives", int'(lives), 3);
    chk("rst_score", int'(score), 0);
    chk("rst_over", int'(game_over), 0);
    chk("rst_coll", int'(collision), 0);
    chk("rst_rgb", int'(rgb), 0);
    chk("rst_state", int'(dut.state), S_PLAY);
    reset = 1'b0;
    step();

    pix(310, 420, 1'b1, 1'b0, 1'b0);
    chk("chick_px", int'(rgb), 2);
    pix(5, 40, 1'b1, 1'b0, 1'b0);
    chk("obst_px", int'(rgb), 4);
    pix(600, 10, 1'b1, 1'b0, 1'b0);
    chk("bg_px", int'(rgb), 1);
    pix(310, 420, 1'b0, 1'b0, 1'b0);
    chk("blank_px", int'(rgb), 0);

    for (int k = 0; k < 10; k++) press();
    chk("score10", int'(score), 10);
    chk("y3_wrap", int'(dut_y[3]), 32);

    do_hit(2, S_FLASH);
    chk("hit_rgb_y2", int'(dut_y[2]), 384);
    pix(310, 420, 1'b1, 1'b0, 1'b0);
    flash_run();
    do_hit(1, S_FLASH);
    flash_run();
    do_hit(0, S_OVER);
    chk("game_over", int'(game_over), 1);
    pix(600, 10, 1'b1, 1'b0, 1'b1);
    chk("over_bg", int'(rgb), 0);
    sp[0] = 3;
    tick(1'b0, 0);
    sp[0] = 0;
    press();
    chk("restart_lives", int'(lives), 3);
    chk("restart_st", int'(dut.state), S_PLAY);
    chk("restart_go", int'(game_over), 0);
    for (int i = 0; i < 4; i++)
      chk("restart_x", int'(dut_x[i]), 160 * i);

    for (int t = 1; t <= 92; t++) begin
      sp[0] = 7;
      dr[0] = 1'b0;
      if (t == 1) begin
        sp[1] = 2;
        dr[1] = 1'b0;
      end else if (t <= 33 || t == 92) begin
        sp[1] = 5;
        dr[1] = 1'b1;
      end else begin
        sp[1] = 0;
      end
      for (int i = 2; i < 4; i++) begin
        sp[i] = int'($urandom_range(0, 7));
        dr[i] = 1'($urandom_range(0, 1));
      end
      if (t == 91) begin
        tick(1'b0, 0);
        chk("x0_637", int'(dut_x[0]), 637);
        chk("x1_2", int'(dut_x[1]), 2);
      end else begin
        tick(t == 92, 0);
      end
    end
    chk("x0_wrap", int'(dut_x[0]), 4);
    chk("x1_wrap", int'(dut_x[1]), 637);
    chk("tick_press", int'(score), 1);
    for (int i = 0; i < 4; i++) sp[i] = 0;

    for (int k = 0; k < 300; k++) press();
    chk("score_sat", int'(score), 255);

    hpos = 10'd310;
    vpos = 10'd420;
    display_on = 1'b1;
    step();
    chk("pre_rst_rgb", int'(rgb),
        exp_rgb(310, 420, 1'b1, 1'b0, 1'b0));
    #2;
    reset = 1'b1;
    #1;
    chk("async_rgb", int'(rgb), 0);
    chk("async_score", int'(score), 0);
    chk("async_lives", int'(lives), 3);
    display_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
